// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, registers the fetched word into IF/ID,
// and handles stall, branch/jump redirect with a one-bubble flush, and halt.
module fetch_unit #(
    parameter int unsigned              PC_WIDTH  = 8,
    parameter logic [PC_WIDTH-1:0]      RESET_PC  = '0,
    parameter logic [31:0]              HALT_WORD = 32'hFFFF_FFFF,
    parameter logic [31:0]              NOP_WORD  = 32'h0000_0000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic [31:0]         instruction,
    output logic [PC_WIDTH-1:0] pc,
    output logic [31:0]         ifid_instruction,
    output logic [PC_WIDTH-1:0] ifid_pc_plus1,
    output logic                ifid_valid,
    output logic                halted,
    output logic [15:0]         fetch_count
);

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    state_t state, state_next;

    logic [PC_WIDTH-1:0] pc_next;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [31:0]         ifid_instruction_next;
    logic [PC_WIDTH-1:0] ifid_pc_plus1_next;
    logic                ifid_valid_next;
    logic                halted_next;
    logic [15:0]         fetch_count_next;
    logic [15:0]         fetch_count_inc;

    // Modulo-2^PC_WIDTH increment; 255+1 wraps to 0 for the default width.
    assign pc_inc          = pc + PC_WIDTH'(1);
    assign fetch_count_inc = (fetch_count == 16'hFFFF) ? fetch_count : fetch_count + 16'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next            = state;
        pc_next               = pc;
        ifid_instruction_next = ifid_instruction;
        ifid_pc_plus1_next    = ifid_pc_plus1;
        ifid_valid_next       = ifid_valid;
        halted_next           = halted;
        fetch_count_next      = fetch_count;

        case (state)
            RUN: begin
                if (branch_taken || jump) begin
                    // A halt marker seen while redirecting is on the wrong path.
                    pc_next               = jump ? jump_target : branch_target;
                    ifid_instruction_next = NOP_WORD;
                    ifid_pc_plus1_next    = '0;
                    ifid_valid_next       = 1'b0;
                end else if (stall) begin
                    pc_next = pc;
                end else if (instruction == HALT_WORD) begin
                    state_next            = HALT;
                    halted_next           = 1'b1;
                    ifid_instruction_next = NOP_WORD;
                    ifid_valid_next       = 1'b0;
                end else begin
                    pc_next               = pc_inc;
                    ifid_instruction_next = instruction;
                    ifid_pc_plus1_next    = pc_inc;
                    ifid_valid_next       = 1'b1;
                    fetch_count_next      = fetch_count_inc;
                end
            end
            HALT: begin
                ifid_instruction_next = NOP_WORD;
                ifid_valid_next       = 1'b0;
                halted_next           = 1'b1;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc               <= RESET_PC;
            ifid_instruction <= NOP_WORD;
            ifid_pc_plus1    <= '0;
            ifid_valid       <= 1'b0;
            halted           <= 1'b0;
            fetch_count      <= '0;
        end else begin
            pc               <= pc_next;
            ifid_instruction <= ifid_instruction_next;
            ifid_pc_plus1    <= ifid_pc_plus1_next;
            ifid_valid       <= ifid_valid_next;
            halted           <= halted_next;
            fetch_count      <= fetch_count_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed per-cycle stimulus pushes the
// hand-computed post-edge state; a negedge monitor pops and compares.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic        jump;
    logic [7:0]  jump_target;
    logic [31:0] instruction;
    logic [7:0]  pc;
    logic [31:0] ifid_instruction;
    logic [7:0]  ifid_pc_plus1;
    logic        ifid_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [31:0] mem [256];

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] ins;
        logic [7:0]  pp1;
        logic        valid;
        logic        halted;
        logic [15:0] cnt;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   step_id = 0;

    fetch_unit #(
        .PC_WIDTH (8),
        .RESET_PC (8'd0),
        .HALT_WORD(32'hFFFF_FFFF),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .jump            (jump),
        .jump_target     (jump_target),
        .instruction     (instruction),
        .pc              (pc),
        .ifid_instruction(ifid_instruction),
        .ifid_pc_plus1   (ifid_pc_plus1),
        .ifid_valid      (ifid_valid),
        .halted          (halted),
        .fetch_count     (fetch_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Combinational instruction memory addressed by pc.
    assign instruction = mem[pc];

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests_run++;
            if (pc !== e.pc || ifid_instruction !== e.ins || ifid_pc_plus1 !== e.pp1 ||
                ifid_valid !== e.valid || halted !== e.halted || fetch_count !== e.cnt) begin
                tests_failed++;
                $display("FAIL step%0d: got pc=%0d ins=%h pp1=%0d v=%b h=%b cnt=%0d, expected pc=%0d ins=%h pp1=%0d v=%b h=%b cnt=%0d",
                         e.id, pc, ifid_instruction, ifid_pc_plus1, ifid_valid, halted, fetch_count,
                         e.pc, e.ins, e.pp1, e.valid, e.halted, e.cnt);
            end
        end
    end

    task automatic drive(input logic rst, input logic st, input logic br, input logic [7:0] bt,
                         input logic j, input logic [7:0] jt);
        reset         = rst;
        stall         = st;
        branch_taken  = br;
        branch_target = bt;
        jump          = j;
        jump_target   = jt;
    endtask

    task automatic tick(input logic [7:0] e_pc, input logic [31:0] e_ins, input logic [7:0] e_pp1,
                        input logic e_v, input logic e_h, input logic [15:0] e_cnt);
        exp_t e;
        @(posedge clock);
        e.pc = e_pc; e.ins = e_ins; e.pp1 = e_pp1;
        e.valid = e_v; e.halted = e_h; e.cnt = e_cnt;
        e.id = step_id;
        step_id++;
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
        mem[7] = 32'hFFFF_FFFF;
        drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
        @(negedge clock);

        // Reset state.
        tick(8'd0, 32'h0, 8'd0, 1'b0, 1'b0, 16'd0);
        tick(8'd0, 32'h0, 8'd0, 1'b0, 1'b0, 16'd0);

        // Straight-line program 0..6 then halt marker at 7.
        idle();
        for (int k = 1; k <= 7; k++)
            tick(8'(k), 32'hA000_0000 | (k - 1), 8'(k), 1'b1, 1'b0, 16'(k));
        tick(8'd7, 32'h0, 8'd7, 1'b0, 1'b1, 16'd7);
        drive(1'b0, 1'b1, 1'b1, 8'd2, 1'b1, 8'd9);
        tick(8'd7, 32'h0, 8'd7, 1'b0, 1'b1, 16'd7);

        // Reset out of HALT.
        drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
        tick(8'd0, 32'h0, 8'd0, 1'b0, 1'b0, 16'd0);

        // Fetch to pc=3, then stall 3 cycles.
        idle();
        tick(8'd1, 32'hA000_0000, 8'd1, 1'b1, 1'b0, 16'd1);
        tick(8'd2, 32'hA000_0001, 8'd2, 1'b1, 1'b0, 16'd2);
        tick(8'd3, 32'hA000_0002, 8'd3, 1'b1, 1'b0, 16'd3);
        drive(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
        repeat (3) tick(8'd3, 32'hA000_0002, 8'd3, 1'b1, 1'b0, 16'd3);
        idle();
        tick(8'd4, 32'hA000_0003, 8'd4, 1'b1, 1'b0, 16'd4);

        // Branch at pc=4 to 20.
        drive(1'b0, 1'b0, 1'b1, 8'd20, 1'b0, 8'd0);
        tick(8'd20, 32'h0, 8'd0, 1'b0, 1'b0, 16'd4);
        idle();
        tick(8'd21, 32'hA000_0014, 8'd21, 1'b1, 1'b0, 16'd5);

        // Branch + jump + stall: jump wins, stall overridden.
        drive(1'b0, 1'b1, 1'b1, 8'd10, 1'b1, 8'd30);
        tick(8'd30, 32'h0, 8'd0, 1'b0, 1'b0, 16'd5);
        idle();
        tick(8'd31, 32'hA000_001E, 8'd31, 1'b1, 1'b0, 16'd6);

        // Jump to 255, then wrap.
        drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd255);
        tick(8'd255, 32'h0, 8'd0, 1'b0, 1'b0, 16'd6);
        idle();
        tick(8'd0, 32'hA000_00FF, 8'd0, 1'b1, 1'b0, 16'd7);

        // Jump onto the halt marker, then redirect away from it in the same cycle.
        drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd7);
        tick(8'd7, 32'h0, 8'd0, 1'b0, 1'b0, 16'd7);
        drive(1'b0, 1'b0, 1'b1, 8'd5, 1'b0, 8'd0);
        tick(8'd5, 32'h0, 8'd0, 1'b0, 1'b0, 16'd7);
        idle();
        tick(8'd6, 32'hA000_0005, 8'd6, 1'b1, 1'b0, 16'd8);
        tick(8'd7, 32'hA000_0006, 8'd7, 1'b1, 1'b0, 16'd9);
        tick(8'd7, 32'h0, 8'd7, 1'b0, 1'b1, 16'd9);

        // HALT ignores jump, stall and branch.
        drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd3);
        tick(8'd7, 32'h0, 8'd7, 1'b0, 1'b1, 16'd9);
        drive(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
        tick(8'd7, 32'h0, 8'd7, 1'b0, 1'b1, 16'd9);
        drive(1'b0, 1'b0, 1'b1, 8'd12, 1'b0, 8'd0);
        tick(8'd7, 32'h0, 8'd7, 1'b0, 1'b1, 16'd9);

        // Reset from HALT, then reset during a stall.
        drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
        tick(8'd0, 32'h0, 8'd0, 1'b0, 1'b0, 16'd0);
        idle();
        tick(8'd1, 32'hA000_0000, 8'd1, 1'b1, 1'b0, 16'd1);
        drive(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
        tick(8'd0, 32'h0, 8'd0, 1'b0, 1'b0, 16'd0);

        idle();
        @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
